bus_transfer_sequencer: RTL and testbench

- Sequences register-to-register transfers over one shared 8-bit bus built from octal edge-triggered registers with synchronous clear and tri-state outputs.
- Arbitrates round-robin among NUM_REQ requesters. Each request names a source register, a destination register and an optional clear.
- Drives per-register OE_bar and Load strobes and the shared Clear_bar line, then acknowledges the winning requester.
- Sits between processor control logic / DMA-style agents and the register bank.

---
 rtl/bus_transfer_sequencer_pkg.sv | 25 ++
 rtl/bus_transfer_sequencer_rr_arbiter.sv | 38 +++
 rtl/bus_transfer_sequencer.sv | 168 ++++++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared types and helpers for the bus transfer sequencer: FSM encoding,
// register-index legality check and index-to-one-hot decode.
package bus_transfer_sequencer_pkg;

  localparam int MAX_SEL_W = 5;
  localparam int MAX_REGS  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  function automatic logic idx_legal(input logic [MAX_SEL_W-1:0] idx, input int num_regs);
    return (int'(idx) < num_regs);
  endfunction

  function automatic logic [MAX_REGS-1:0] idx_onehot(input logic [MAX_SEL_W-1:0] idx);
    logic [MAX_REGS-1:0] oh;
    oh = {{(MAX_REGS-1){1'b0}}, 1'b1} << idx;
    return oh;
  endfunction

endpackage

// File: rtl/bus_transfer_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, circularly.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  int                idx_s;
  logic [PTR_W-1:0]  pos_s;

  // Scan requesters starting from the pointer and grant the first one found
  always_comb begin
    grant = {NUM_REQ{1'b0}};
    valid = 1'b0;
    idx_s = 0;
    pos_s = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_s = int'(ptr) + i;
      if (idx_s >= NUM_REQ) begin
        idx_s = idx_s - NUM_REQ;
      end else begin
        idx_s = idx_s;
      end
      pos_s = PTR_W'(idx_s);
      if (!valid && req[pos_s]) begin
        grant[pos_s] = 1'b1;
        valid        = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Round-robin sequencer for register-to-register transfers over a shared
// tri-state bus: IDLE -> DRIVE -> LOAD -> ACK, all outputs registered.
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int NUM_REGS      = 4,
  parameter int SEL_W         = 2,
  parameter int SETTLE_CYCLES = 1,
  localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*SEL_W-1:0] Req_src,
  input  logic [NUM_REQ*SEL_W-1:0] Req_dst,
  input  logic [NUM_REQ-1:0]       Req_clear,
  output logic [NUM_REQ-1:0]       Grant,
  output logic [NUM_REQ-1:0]       Ack,
  output logic                     Err,
  output logic                     Busy,
  output logic [NUM_REGS-1:0]      OE_bar,
  output logic [NUM_REGS-1:0]      Load,
  output logic                     Clear_bar
);

  state_t               state_r;
  logic [PTR_W-1:0]     ptr_r;
  logic [PTR_W-1:0]     gidx_r;
  logic [3:0]           cnt_r;
  logic [SEL_W-1:0]     dst_r;
  logic                 clear_r;
  logic [NUM_REQ-1:0]   grant_r;
  logic [NUM_REQ-1:0]   ack_r;
  logic                 err_r;
  logic                 busy_r;
  logic [NUM_REGS-1:0]  oe_bar_r;
  logic [NUM_REGS-1:0]  load_r;
  logic                 clear_bar_r;

  logic [NUM_REQ-1:0]   arb_grant_s;
  logic                 arb_valid_s;
  logic [SEL_W-1:0]     win_src_s;
  logic [SEL_W-1:0]     win_dst_s;
  logic                 win_clear_s;
  logic [PTR_W-1:0]     win_idx_s;
  logic                 win_legal_s;
  logic [MAX_REGS-1:0]  src_oh_s;
  logic [MAX_REGS-1:0]  dst_oh_s;
  logic                 unused_dec_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (Req),
    .ptr   (ptr_r),
    .grant (arb_grant_s),
    .valid (arb_valid_s)
  );

  // Extract the winning requester's fields and index from the one-hot grant
  always_comb begin
    win_src_s   = {SEL_W{1'b0}};
    win_dst_s   = {SEL_W{1'b0}};
    win_clear_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant_s[i]) begin
        win_src_s   = Req_src[i*SEL_W +: SEL_W];
        win_dst_s   = Req_dst[i*SEL_W +: SEL_W];
        win_clear_s = Req_clear[i];
        win_idx_s   = PTR_W'(i);
      end else begin
        win_idx_s   = win_idx_s;
      end
    end
  end

  // A clear transfer never drives the bus, so its source index is irrelevant
  assign win_legal_s  = idx_legal(MAX_SEL_W'(win_dst_s), NUM_REGS) &&
                        (win_clear_s || idx_legal(MAX_SEL_W'(win_src_s), NUM_REGS));
  assign src_oh_s     = idx_onehot(MAX_SEL_W'(win_src_s));
  assign dst_oh_s     = idx_onehot(MAX_SEL_W'(dst_r));
  assign unused_dec_s = ^{src_oh_s, dst_oh_s};

  // Transfer FSM with settle counter, round-robin pointer and registered strobes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {PTR_W{1'b0}};
      gidx_r      <= {PTR_W{1'b0}};
      cnt_r       <= 4'd0;
      dst_r       <= {SEL_W{1'b0}};
      clear_r     <= 1'b0;
      grant_r     <= {NUM_REQ{1'b0}};
      ack_r       <= {NUM_REQ{1'b0}};
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      oe_bar_r    <= {NUM_REGS{1'b1}};
      load_r      <= {NUM_REGS{1'b0}};
      clear_bar_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_valid_s) begin
            grant_r <= arb_grant_s;
            busy_r  <= 1'b1;
            gidx_r  <= win_idx_s;
            dst_r   <= win_dst_s;
            clear_r <= win_clear_s;
            cnt_r   <= 4'(SETTLE_CYCLES - 1);
            if (win_legal_s) begin
              state_r  <= ST_DRIVE;
              oe_bar_r <= win_clear_s ? {NUM_REGS{1'b1}} : ~src_oh_s[NUM_REGS-1:0];
            end else begin
              state_r <= ST_ACK;
              ack_r   <= arb_grant_s;
              err_r   <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (cnt_r == 4'd0) begin
            state_r     <= ST_LOAD;
            load_r      <= dst_oh_s[NUM_REGS-1:0];
            clear_bar_r <= ~clear_r;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_LOAD: begin
          state_r     <= ST_ACK;
          load_r      <= {NUM_REGS{1'b0}};
          clear_bar_r <= 1'b1;
          oe_bar_r    <= {NUM_REGS{1'b1}};
          ack_r       <= grant_r;
        end
        ST_ACK: begin
          state_r <= ST_IDLE;
          grant_r <= {NUM_REQ{1'b0}};
          ack_r   <= {NUM_REQ{1'b0}};
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          ptr_r   <= (gidx_r == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : gidx_r + PTR_W'(1);
        end
        default: begin
          state_r     <= ST_IDLE;
          grant_r     <= {NUM_REQ{1'b0}};
          ack_r       <= {NUM_REQ{1'b0}};
          err_r       <= 1'b0;
          busy_r      <= 1'b0;
          oe_bar_r    <= {NUM_REGS{1'b1}};
          load_r      <= {NUM_REGS{1'b0}};
          clear_bar_r <= 1'b1;
        end
      endcase
    end
  end

  assign Grant     = grant_r;
  assign Ack       = ack_r;
  assign Err       = err_r;
  assign Busy      = busy_r;
  assign OE_bar    = oe_bar_r;
  assign Load      = load_r;
  assign Clear_bar = clear_bar_r;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench: dut (SEL_W=3, settle 1) and dut3 (SEL_W=2, settle 3).
module tb_bus_transfer_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  Req, Req_clear;
  logic [11:0] Req_src, Req_dst;
  logic [3:0]  Grant, Ack, OE_bar, Load;
  logic        Err, Busy, Clear_bar;

  logic [3:0]  r3_req, r3_clear;
  logic [7:0]  r3_src, r3_dst;
  logic [3:0]  r3_grant, r3_ack, r3_oe_bar, r3_load;
  logic        r3_err, r3_busy, r3_clear_bar;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 Clk = ~Clk;

  bus_transfer_sequencer #(.NUM_REQ(4), .NUM_REGS(4), .SEL_W(3), .SETTLE_CYCLES(1)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Req_src(Req_src), .Req_dst(Req_dst),
    .Req_clear(Req_clear), .Grant(Grant), .Ack(Ack), .Err(Err), .Busy(Busy),
    .OE_bar(OE_bar), .Load(Load), .Clear_bar(Clear_bar)
  );

  bus_transfer_sequencer #(.NUM_REQ(4), .NUM_REGS(4), .SEL_W(2), .SETTLE_CYCLES(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Req(r3_req), .Req_src(r3_src), .Req_dst(r3_dst),
    .Req_clear(r3_clear), .Grant(r3_grant), .Ack(r3_ack), .Err(r3_err), .Busy(r3_busy),
    .OE_bar(r3_oe_bar), .Load(r3_load), .Clear_bar(r3_clear_bar)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] s, input logic [2:0] d, input logic c);
    Req_src[i*3 +: 3] = s;
    Req_dst[i*3 +: 3] = d;
    Req_clear[i]      = c;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  initial begin
    int acks;
    int order[4];
    int cyc[4];
    bit overlap;
    logic [3:0] first_ack, second_ack;

    Reset = 1'b1; Req = 4'd0; Req_clear = 4'd0; Req_src = 12'd0; Req_dst = 12'd0;
    r3_req = 4'd0; r3_clear = 4'd0; r3_src = 8'd0; r3_dst = 8'd0;
    tick(); tick();
    check_eq("rst_grant", 32'(Grant), 32'h0);
    check_eq("rst_ack", 32'(Ack), 32'h0);
    check_eq("rst_busy", 32'(Busy), 32'h0);
    check_eq("rst_oe", 32'(OE_bar), 32'hF);
    check_eq("rst_load", 32'(Load), 32'h0);
    check_eq("rst_clrb", 32'(Clear_bar), 32'h1);
    Reset = 1'b0;

    // 1: single transfer src 2 -> dst 1
    set_req(0, 3'd2, 3'd1, 1'b0); Req = 4'b0001;
    tick();
    check_eq("t1_c1_oe", 32'(OE_bar), 32'hB);
    check_eq("t1_c1_grant", 32'(Grant), 32'h1);
    check_eq("t1_c1_load", 32'(Load), 32'h0);
    tick();
    check_eq("t1_c2_oe", 32'(OE_bar), 32'hB);
    check_eq("t1_c2_load", 32'(Load), 32'h2);
    tick();
    check_eq("t1_c3_ack", 32'(Ack), 32'h1);
    check_eq("t1_c3_oe", 32'(OE_bar), 32'hF);
    check_eq("t1_c3_err", 32'(Err), 32'h0);
    Req = 4'b0000;
    tick();
    check_eq("t1_c4_busy", 32'(Busy), 32'h0);
    check_eq("t1_c4_grant", 32'(Grant), 32'h0);

    // 2: all four requesters after reset, served 0..3 every 4 cycles
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 3'(i), 3'(3 - i), 1'b0);
    Req = 4'b1111; acks = 0; overlap = 1'b0;
    for (int c = 1; c <= 40 && acks < 4; c++) begin
      tick();
      if ($countones(~OE_bar) > 1) overlap = 1'b1;
      if (Ack != 4'd0) begin
        order[acks] = oh_idx(Ack);
        cyc[acks]   = c;
        acks++;
        Req = Req & ~Ack;
      end
    end
    check_eq("t2_acks", 32'(acks), 32'd4);
    for (int i = 0; i < 4 && i < acks; i++) begin
      check_eq("t2_order", 32'(order[i]), 32'(i));
      check_eq("t2_cycle", 32'(cyc[i]), 32'(3 + 4 * i));
    end
    check_eq("t2_oe_overlap", 32'(overlap), 32'h0);
    tick();
    check_eq("t2_idle_busy", 32'(Busy), 32'h0);

    // 3: clear transfer on requester 2 into register 3; src out of range is ignored
    set_req(2, 3'd7, 3'd3, 1'b1); Req = 4'b0100;
    tick();
    check_eq("t3_c1_oe", 32'(OE_bar), 32'hF);
    check_eq("t3_c1_grant", 32'(Grant), 32'h4);
    tick();
    check_eq("t3_c2_oe", 32'(OE_bar), 32'hF);
    check_eq("t3_c2_load", 32'(Load), 32'h8);
    check_eq("t3_c2_clrb", 32'(Clear_bar), 32'h0);
    tick();
    check_eq("t3_c3_ack", 32'(Ack), 32'h4);
    check_eq("t3_c3_clrb", 32'(Clear_bar), 32'h1);
    check_eq("t3_c3_err", 32'(Err), 32'h0);
    Req = 4'b0000; Req_clear = 4'b0000;
    tick();

    // 4: out-of-range source, then out-of-range destination
    set_req(0, 3'd5, 3'd1, 1'b0); Req = 4'b0001;
    tick();
    check_eq("t4_src_ack", 32'(Ack), 32'h1);
    check_eq("t4_src_err", 32'(Err), 32'h1);
    check_eq("t4_src_oe", 32'(OE_bar), 32'hF);
    check_eq("t4_src_load", 32'(Load), 32'h0);
    check_eq("t4_src_clrb", 32'(Clear_bar), 32'h1);
    check_eq("t4_src_busy", 32'(Busy), 32'h1);
    Req = 4'b0000;
    tick();
    check_eq("t4_src_done", 32'({Ack, Err, Busy}), 32'h0);
    set_req(1, 3'd0, 3'd4, 1'b0); Req = 4'b0010;
    tick();
    check_eq("t4_dst_ack", 32'(Ack), 32'h2);
    check_eq("t4_dst_err", 32'(Err), 32'h1);
    check_eq("t4_dst_oe", 32'(OE_bar), 32'hF);
    Req = 4'b0000;
    tick();

    // 5: reset during LOAD aborts without Ack; pointer returns to 0
    set_req(1, 3'd0, 3'd2, 1'b0); Req = 4'b0010;
    tick();
    check_eq("t5_c1_oe", 32'(OE_bar), 32'hE);
    tick();
    check_eq("t5_c2_load", 32'(Load), 32'h4);
    Reset = 1'b1;
    set_req(0, 3'd3, 3'd0, 1'b0); Req = 4'b0011;
    tick();
    check_eq("t5_rst_load", 32'(Load), 32'h0);
    check_eq("t5_rst_oe", 32'(OE_bar), 32'hF);
    check_eq("t5_rst_grant", 32'(Grant), 32'h0);
    check_eq("t5_rst_ack", 32'(Ack), 32'h0);
    Reset = 1'b0;
    tick();
    check_eq("t5_regrant", 32'(Grant), 32'h1);
    check_eq("t5_regrant_oe", 32'(OE_bar), 32'h7);
    acks = 0; first_ack = 4'd0; second_ack = 4'd0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      tick();
      if (Ack != 4'd0) begin
        if (acks == 0) first_ack = Ack; else second_ack = Ack;
        acks++;
        Req = Req & ~Ack;
      end
    end
    check_eq("t5_acks", 32'(acks), 32'd2);
    check_eq("t5_first", 32'(first_ack), 32'h1);
    check_eq("t5_second", 32'(second_ack), 32'h2);
    tick();

    // 6: settle 3; requester 1 holds Req through Ack while 3 pends
    r3_src = 8'b10_00_00_00; r3_dst = 8'b11_00_01_00; r3_req = 4'b1010;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check_eq("t6_drive_oe", 32'(r3_oe_bar), 32'hE);
      check_eq("t6_drive_load", 32'(r3_load), 32'h0);
      check_eq("t6_drive_grant", 32'(r3_grant), 32'h2);
    end
    tick();
    check_eq("t6_c4_load", 32'(r3_load), 32'h2);
    check_eq("t6_c4_oe", 32'(r3_oe_bar), 32'hE);
    tick();
    check_eq("t6_c5_ack", 32'(r3_ack), 32'h2);
    tick();
    check_eq("t6_c6_busy", 32'(r3_busy), 32'h0);
    tick();
    check_eq("t6_c7_grant", 32'(r3_grant), 32'h8);
    check_eq("t6_c7_oe", 32'(r3_oe_bar), 32'hB);
    tick(); tick(); tick();
    check_eq("t6_c10_load", 32'(r3_load), 32'h8);
    tick();
    check_eq("t6_c11_ack", 32'(r3_ack), 32'h8);
    r3_req = 4'b0010;
    tick(); tick();
    check_eq("t6_c13_grant", 32'(r3_grant), 32'h2);
    r3_req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
